// File: rtl/cdce62002_pkg.sv
// cdce62002_pkg: shared word-format constants and readback FSM states for the CDCE62002 SPI blocks
package cdce62002_pkg;
  localparam int WORD_BITS = 32;
  localparam int ADDR_BITS = 4;
  localparam int DATA_BITS = 28;
  localparam logic [3:0] READ_CMD_ADDR = 4'hE;
  typedef enum logic [2:0] {IDLE, CMD_SHIFT, CMD_LATCH, READ_SHIFT, READ_LATCH, COMPARE, DONE} state_t;
endpackage

// File: rtl/cdce62002_readback_if.sv
// cdce62002_readback_if: sequencer handshake, expected/result bus and SPI pins of the readback block
interface cdce62002_readback_if #(
  parameter int NUM_REGS = 2
);
  import cdce62002_pkg::*;
  logic start;
  logic [NUM_REGS*DATA_BITS-1:0] expected;
  logic busy, done, pass;
  logic [ADDR_BITS-1:0] fail_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic spi_clk, spi_le, spi_mosi, spi_miso;
  modport master (
    output start, expected, spi_miso,
    input busy, done, pass, fail_addr, rd_data, spi_clk, spi_le, spi_mosi
  );
  modport slave (
    input start, expected, spi_miso,
    output busy, done, pass, fail_addr, rd_data, spi_clk, spi_le, spi_mosi
  );
endinterface

// File: rtl/cdce62002_spi_shifter.sv
// cdce62002_spi_shifter: one LSB-first 32-bit SPI frame; clk low then high CLK_DIV cycles per bit
module cdce62002_spi_shifter
  import cdce62002_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go_i,
  input  logic [WORD_BITS-1:0] tx_word_i,
  input  logic                 miso_i,
  output logic                 frame_done_o,
  output logic [WORD_BITS-1:0] rx_word_o,
  output logic                 spi_clk_o,
  output logic                 spi_le_o,
  output logic                 spi_mosi_o
);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(WORD_BITS);
  localparam logic [PW-1:0] PH_HI = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_END = PW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_END = BW'(WORD_BITS - 1);
  logic active_q, clk_q, le_q, mosi_q;
  logic [PW-1:0] ph_q;
  logic [BW-1:0] bit_q;
  logic [WORD_BITS-1:0] tx_q, rx_q;
  assign frame_done_o = active_q && ph_q == PH_END && bit_q == BIT_END;
  assign rx_word_o = rx_q;
  assign spi_clk_o = clk_q;
  assign spi_le_o = le_q;
  assign spi_mosi_o = mosi_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      ph_q <= '0;
      bit_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      clk_q <= 1'b0;
      le_q <= 1'b1;
      mosi_q <= 1'b0;
    end else if (go_i) begin
      active_q <= 1'b1;
      ph_q <= '0;
      bit_q <= '0;
      tx_q <= tx_word_i >> 1;
      clk_q <= 1'b0;
      le_q <= 1'b0;
      mosi_q <= tx_word_i[0];
    end else if (active_q) begin
      ph_q <= ph_q == PH_END ? '0 : ph_q + 1'b1;
      // miso is captured on the same edge that drives spi_clk high
      if (ph_q == PH_HI) begin
        clk_q <= 1'b1;
        rx_q <= {miso_i, rx_q[WORD_BITS-1:1]};
      end
      if (ph_q == PH_END) begin
        clk_q <= 1'b0;
        bit_q <= bit_q + 1'b1;
        tx_q <= tx_q >> 1;
        mosi_q <= bit_q == BIT_END ? 1'b0 : tx_q[0];
        le_q <= bit_q == BIT_END;
        active_q <= bit_q != BIT_END;
      end
    end
  end
endmodule

// File: rtl/cdce62002_readback.sv
// cdce62002_readback: reads back CDCE62002 registers 0..NUM_REGS-1 over SPI and checks them against expected payloads
module cdce62002_readback
  import cdce62002_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NUM_REGS = 2
) (
  input logic sysclk,
  input logic reset,
  cdce62002_readback_if.slave bus
);
  localparam int LW = $clog2(2 * CLK_DIV);
  localparam logic [LW-1:0] LAT_END = LW'(2 * CLK_DIV - 1);
  state_t state_q;
  logic [ADDR_BITS-1:0] idx_q, fail_q, nxt_idx_d;
  logic [LW-1:0] lat_q;
  logic [NUM_REGS*DATA_BITS-1:0] exp_q;
  logic [DATA_BITS-1:0] rd_q;
  logic busy_q, done_q, pass_q;
  logic lat_end, last, match, go;
  logic [WORD_BITS-1:0] tx_word, rx_word;
  logic spi_clk, spi_le, spi_mosi, frame_done, unused_addr;
  always_comb begin
    lat_end = lat_q == LAT_END;
    last = idx_q == ADDR_BITS'(NUM_REGS - 1);
    match = rx_word[WORD_BITS-1:ADDR_BITS] == exp_q[int'(idx_q)*DATA_BITS +: DATA_BITS];
    nxt_idx_d = state_q == IDLE ? '0 : idx_q + 1'b1;
    go = (state_q == IDLE && bus.start) || (state_q == CMD_LATCH && lat_end) ||
         (state_q == COMPARE && match && !last);
    tx_word = state_q == CMD_LATCH ? '0 : {{(WORD_BITS-8){1'b0}}, nxt_idx_d, READ_CMD_ADDR};
  end
  assign unused_addr = ^rx_word[ADDR_BITS-1:0];
  cdce62002_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk(sysclk),
    .rst(reset),
    .go_i(go),
    .tx_word_i(tx_word),
    .miso_i(bus.spi_miso),
    .frame_done_o(frame_done),
    .rx_word_o(rx_word),
    .spi_clk_o(spi_clk),
    .spi_le_o(spi_le),
    .spi_mosi_o(spi_mosi)
  );
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      fail_q <= '0;
      lat_q <= '0;
      exp_q <= '0;
      rd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lat_q <= (state_q == CMD_LATCH || state_q == READ_LATCH) ? lat_q + 1'b1 : '0;
      case (state_q)
        IDLE: if (bus.start) begin
          exp_q <= bus.expected;
          idx_q <= '0;
          pass_q <= 1'b0;
          fail_q <= '0;
          busy_q <= 1'b1;
          state_q <= CMD_SHIFT;
        end
        CMD_SHIFT: if (frame_done) state_q <= CMD_LATCH;
        CMD_LATCH: if (lat_end) state_q <= READ_SHIFT;
        READ_SHIFT: if (frame_done) state_q <= READ_LATCH;
        READ_LATCH: if (lat_end) state_q <= COMPARE;
        COMPARE: begin
          rd_q <= rx_word[WORD_BITS-1:ADDR_BITS];
          // first mismatch aborts; later registers are never addressed
          if (!match || last) begin
            pass_q <= match;
            fail_q <= match ? '0 : idx_q;
            done_q <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= nxt_idx_d;
            state_q <= CMD_SHIFT;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.fail_addr = fail_q;
  assign bus.rd_data = rd_q;
  assign bus.spi_clk = spi_clk;
  assign bus.spi_le = spi_le;
  assign bus.spi_mosi = spi_mosi;
endmodule
